// File: rtl/rng_arbiter.sv
// Shared random-number server: one 8-bit LFSR, round-robin grant among N_REQ requesters,
// unbiased 0..bound results by mask-and-reject with a bounded retry count and masked fallback.
module rng_arbiter #(
    parameter int N_REQ     = 4,
    parameter int SHIFTS    = 8,
    parameter int MAX_RETRY = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               seed_load,
    input  logic [7:0]         seed,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] bound,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         data_out,
    output logic               busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, gnt, sel, gnt_inc;
    logic [7:0]    lfsr, bound_q, mask_q;
    logic [7:0]    bound_sel, mask_sel, m1, m2, cand;
    logic [3:0]    retry, cnt;
    logic          any_req, gnt_req, last_shift, accept, can_retry;

    // Cyclic search for the first active requester at or above ptr.
    always_comb begin : arb
        int            j;
        logic [PW-1:0] idx;
        any_req = 1'b0;
        sel     = '0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            idx = PW'(j);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        bound_sel = bound[7:0];
        for (int i = 0; i < N_REQ; i++)
            if (sel == PW'(i)) bound_sel = bound[8*i +: 8];
    end

    // Smearing the bound's bits downward yields the smallest 2^k-1 covering it.
    assign m1         = bound_sel | (bound_sel >> 1);
    assign m2         = m1 | (m1 >> 2);
    assign mask_sel   = m2 | (m2 >> 4);

    assign cand       = lfsr & mask_q;
    assign accept     = (cand <= bound_q);
    assign can_retry  = (retry != 4'(MAX_RETRY));
    assign last_shift = (cnt == 4'(SHIFTS - 1));
    assign gnt_req    = req[gnt];
    assign gnt_inc    = (gnt == PW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = DRAW;
            DRAW:    if (!gnt_req)        state_nxt = IDLE;
                     else if (last_shift) state_nxt = CHECK;
            CHECK:   if (!gnt_req)                   state_nxt = IDLE;
                     else if (accept || !can_retry) state_nxt = DONE;
                     else                            state_nxt = DRAW;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state == DONE) ack[gnt] = 1'b1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr     <= 8'h0F;
            ptr      <= '0;
            gnt      <= '0;
            bound_q  <= '0;
            mask_q   <= '0;
            retry    <= '0;
            cnt      <= '0;
            data_out <= 8'h00;
        end else begin
            if (seed_load)
                lfsr <= (seed == 8'h00) ? 8'h0F : seed;
            else if (state == DRAW || (state == IDLE && en))
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[0]};

            case (state)
                IDLE: if (any_req) begin
                    gnt     <= sel;
                    bound_q <= bound_sel;
                    mask_q  <= mask_sel;
                    retry   <= '0;
                    cnt     <= '0;
                end
                DRAW: begin
                    if (!gnt_req) ptr <= gnt_inc;
                    else          cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    if (!gnt_req)
                        ptr <= gnt_inc;
                    else if (accept)
                        data_out <= cand;
                    else if (can_retry) begin
                        retry <= retry + 4'd1;
                        cnt   <= '0;
                    end else
                        // The top mask bit is what pushed cand past bound; dropping it always fits.
                        data_out <= cand & (mask_q >> 1);
                end
                DONE:    ptr <= gnt_inc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed cases plus randomized transactions checked against a
// transaction-level model of the draw/reject/fallback rules.
module tb_rng_arbiter;
    localparam int N  = 4;
    localparam int SH = 8;
    localparam int MR = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic           seed_load = 1'b0;
    logic [7:0]     seed = 8'h00;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] bound = '0;
    logic [N-1:0]   ack, ack0;
    logic [7:0]     data_out, data0;
    logic           busy, busy0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mq;
    logic [31:0] busy_bits;

    always #5 clk = ~clk;

    rng_arbiter #(.N_REQ(N), .SHIFTS(SH), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
        .req(req), .bound(bound), .ack(ack), .data_out(data_out), .busy(busy));

    rng_arbiter #(.N_REQ(N), .SHIFTS(SH), .MAX_RETRY(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
        .req(req), .bound(bound), .ack(ack0), .data_out(data0), .busy(busy0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[0]};
    endfunction

    function automatic logic [7:0] mask_of(input logic [7:0] b);
        for (int k = 0; k <= 8; k++)
            if (((1 << k) - 1) >= int'(b)) return 8'((1 << k) - 1);
        return 8'hFF;
    endfunction

    // One transaction: first round takes 'first' LFSR steps, later rounds SH each.
    task automatic model(input logic [7:0] start, input int first, input logic [7:0] b,
                         input int maxr, output logic [7:0] val, output int cyc,
                         output logic [7:0] q);
        logic [7:0] m, cand;
        int steps;
        q = start; m = mask_of(b); steps = first; val = 8'h00; cyc = 0;
        for (int r = 0; r <= maxr; r++) begin
            for (int s = 0; s < steps; s++) q = lstep(q);
            cand  = q & m;
            cyc   = (r + 1) * (SH + 1) + 1;
            steps = SH;
            if (cand <= b) begin
                val = cand;
                return;
            end
            if (r == maxr) val = cand & (m >> 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ack0", ack0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        mq = 8'h0F;
    endtask

    task automatic load(input logic [7:0] s);
        repeat (2) @(posedge clk);
        #1;
        seed = s; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        mq = (s == 8'h00) ? 8'h0F : s;
    endtask

    // Cycle 0 is the cycle req rises; also perturbs bounds and a neighbour line mid-draw.
    task automatic serve(input int idx, input bit use0, input int seed_at, input logic [7:0] sv,
                         output int cyc, output logic [7:0] d, output logic [N-1:0] a);
        logic [N-1:0] av;
        req[idx] = 1'b1; cyc = -1; d = 8'h00; a = '0; busy_bits = '0;
        for (int c = 0; c < 400; c++) begin
            if (c == seed_at) begin seed = sv; seed_load = 1'b1; end
            if (c == 2) bound = $urandom;
            if (c == 3) req[(idx + 1) % N] = 1'b1;
            if (c == 6) req[(idx + 1) % N] = 1'b0;
            @(negedge clk);
            if (c < 32) busy_bits[c] = use0 ? busy0 : busy;
            av = use0 ? ack0 : ack;
            if (av != '0) begin
                cyc = c; a = av; d = use0 ? data0 : data_out;
                break;
            end
            @(posedge clk); #1;
            seed_load = 1'b0;
        end
        @(posedge clk); #1;
        seed_load = 1'b0;
        req = '0;
    endtask

    initial begin
        logic [7:0]   v, q, d;
        logic [N-1:0] a, e;
        int           cyc, ec, k, c1;
        bit           seen0;

        #2;
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        mq = 8'h0F;

        bound[7:0] = 8'hFF;
        model(mq, SH, 8'hFF, MR, v, ec, q);
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("basic_cycle", cyc, 10);
        chk("basic_data", d, v);
        chk("basic_const", d, 8'hF5);
        chk("basic_ack", a, 4'b0001);
        chk("basic_busy", busy_bits[9:0], 10'b1111111110);

        load(8'h0F); bound[7:0] = 8'h7F;
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("mask7f_cycle", cyc, 10);
        chk("mask7f_data", d, 8'h75);

        load(8'h0F); bound[7:0] = 8'h00;
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("mask00_cycle", cyc, 10);
        chk("mask00_data", d, 8'h00);

        load(8'h0F); bound[7:0] = 8'h70;
        model(mq, SH, 8'h70, MR, v, ec, q);
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("reject_cycle", cyc, 19);
        chk("reject_model_cycle", cyc, ec);
        chk("reject_data", d, 8'h59);

        load(8'h0F); bound[7:0] = 8'h70;
        model(mq, SH, 8'h70, 0, v, ec, q);
        serve(0, 1'b1, -1, 8'h00, cyc, d, a);
        chk("fallback_cycle", cyc, 10);
        chk("fallback_data", d, 8'h35);
        chk("fallback_model", d, v);

        do_reset();
        load(8'h00); bound[7:0] = 8'hFF;
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("seed00_data", d, 8'hF5);

        // Asynchronous reset in the middle of a draw.
        bound[7:0] = 8'hFF; req[0] = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data_out, 0);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        mq = 8'h0F;
        bound[7:0] = 8'hFF;
        serve(0, 1'b0, -1, 8'h00, cyc, d, a);
        chk("midrst_lfsr", d, 8'hF5);

        do_reset();
        bound = '1; req = '1; k = 0;
        for (int c = 0; c < 120 && k < 5; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                e = '0; e[k % N] = 1'b1;
                model(mq, SH, 8'hFF, MR, v, ec, q);
                mq = q;
                chk("fair_ack", ack, e);
                chk("fair_cycle", c, 10 + 11 * k);
                chk("fair_data", data_out, v);
                k++;
            end
            @(posedge clk); #1;
        end
        req = '0;
        chk("fair_count", k, 5);

        do_reset();
        bound = '1; req = 4'b0011; seen0 = 1'b0; c1 = -1; d = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack[0]) seen0 = 1'b1;
            if (ack[1] && c1 < 0) begin c1 = c; d = data_out; end
            @(posedge clk); #1;
            if (c == 3) req[0] = 1'b0;
            if (c1 >= 0) break;
        end
        req = '0;
        model(8'h0F, 12, 8'hFF, MR, v, ec, q);
        chk("abort_no_ack0", seen0, 0);
        chk("abort_ack1_cycle", c1, 15);
        chk("abort_data", d, v);

        for (int it = 0; it < 20; it++) begin
            logic [7:0] s, b, sv;
            int idx, sa;
            s = 8'($urandom);
            load(s);
            k = $urandom_range(0, 5);
            if (k > 0) begin
                en = 1'b1;
                repeat (k) @(posedge clk);
                #1;
                en = 1'b0;
            end
            for (int j = 0; j < k; j++) mq = lstep(mq);
            idx = $urandom_range(0, N - 1);
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 12));
            bound = $urandom;
            bound[8*idx +: 8] = b;
            sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, SH) : -1;
            sv = 8'($urandom);
            if (sa < 0) model(mq, SH, b, MR, v, ec, q);
            else        model((sv == 8'h00) ? 8'h0F : sv, SH - sa, b, MR, v, ec, q);
            serve(idx, 1'b0, sa, sv, cyc, d, a);
            e = '0; e[idx] = 1'b1;
            chk("rnd_cycle", cyc, ec);
            chk("rnd_data", d, v);
            chk("rnd_ack", a, e);
            mq = q;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
